smc_seq: RTL and testbench

- Sequential, parametrised MOSFET evaluator.
- Accepts N_DEV transistor descriptors (W, V_GS, V_DS), one beat per accepted cycle.
- For each device, computes drain current (Id) or transconductance (gm) and insertion-sorts the result into a descending register array.
- After the last beat, emits one weighted sum of either the K largest or the K smallest values. Used as the streaming front-end of the device-selection datapath.

---
 rtl/smc_seq.sv | 141 ++++++++++++++
 tb/tb_smc_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/smc_seq.sv
// smc_seq: streaming MOSFET evaluator. Computes Id or gm per device, insertion-sorts
// the values in descending order and emits a weighted sum of the K largest or smallest.
module smc_seq #(
  parameter int N_DEV = 6,
  parameter int K     = 3,
  parameter int DW    = 3,
  parameter int OUTW  = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      mode,
  input  logic [DW-1:0]   W,
  input  logic [DW-1:0]   V_GS,
  input  logic [DW-1:0]   V_DS,
  output logic            out_valid,
  output logic [OUTW-1:0] out_n
);
  localparam int VW = 3 * DW;
  localparam int PW = 3 * DW + 2;
  localparam int CW = $clog2(N_DEV + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SUM, S_OUT} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_mode;
  logic [VW-1:0]   r_arr [N_DEV];
  logic [OUTW-1:0] r_sum;

  logic            w_accept;
  logic            w_id_sel;
  logic            w_triode;
  logic [DW-1:0]   w_vov;
  logic [PW-1:0]   w_wx;
  logic [PW-1:0]   w_vx;
  logic [PW-1:0]   w_dx;
  logic [PW-1:0]   w_num;
  logic [VW-1:0]   w_val;
  logic [VW-1:0]   w_ins [N_DEV];
  logic [OUTW-1:0] w_term [K];
  logic [OUTW-1:0] w_sum;

  assign in_ready  = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign out_valid = (r_state == S_OUT);
  assign out_n     = (r_state == S_OUT) ? r_sum : '0;
  assign w_accept  = in_valid && in_ready;

  // The first beat of a frame uses the live mode; later beats use the latched one.
  assign w_id_sel = (r_state == S_IDLE) ? mode[0] : r_mode[0];
  assign w_vov    = (V_GS == '0) ? '0 : V_GS - DW'(1);
  assign w_triode = w_vov > V_DS;
  assign w_wx     = PW'(W);
  assign w_vx     = PW'(w_vov);
  assign w_dx     = PW'(V_DS);

  always_comb begin
    w_num = '0;
    if (w_triode) begin
      w_num = w_id_sel ? w_wx * (PW'(2) * w_vx * w_dx - w_dx * w_dx)
                       : PW'(2) * w_wx * w_dx;
    end else begin
      w_num = w_id_sel ? w_wx * w_vx * w_vx
                       : PW'(2) * w_wx * w_vx;
    end
  end

  assign w_val = VW'(w_num / PW'(3));

  // Single-cycle insertion: ties keep existing entries ahead of the new value.
  genvar gi;
  generate
    for (gi = 0; gi < N_DEV; gi++) begin : g_ins
      if (gi == 0) begin : g_head
        assign w_ins[gi] = (r_arr[gi] >= w_val) ? r_arr[gi] : w_val;
      end else begin : g_body
        assign w_ins[gi] = (r_arr[gi] >= w_val)   ? r_arr[gi] :
                           (r_arr[gi-1] >= w_val) ? w_val     : r_arr[gi-1];
      end
    end

    for (gi = 0; gi < K; gi++) begin : g_term
      logic [VW-1:0] w_pick;
      assign w_pick     = r_mode[1] ? r_arr[gi] : r_arr[N_DEV-K+gi];
      assign w_term[gi] = OUTW'(w_pick) * (r_mode[0] ? OUTW'(3 + gi) : OUTW'(1));
    end
  endgenerate

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < K; i++) begin
      w_sum = w_sum + w_term[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = (N_DEV == 1) ? S_SUM : S_LOAD;
      S_LOAD:  if (w_accept && (r_cnt == CW'(N_DEV - 1))) w_state_next = S_SUM;
      S_SUM:   w_state_next = S_OUT;
      S_OUT:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_mode <= '0;
      r_sum  <= '0;
      for (int i = 0; i < N_DEV; i++) r_arr[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_LOAD: begin
          if (w_accept) begin
            for (int i = 0; i < N_DEV; i++) r_arr[i] <= w_ins[i];
            r_cnt <= r_cnt + CW'(1);
            if (r_state == S_IDLE) r_mode <= mode;
          end
        end
        S_SUM: r_sum <= w_sum;
        S_OUT: begin
          r_cnt <= '0;
          for (int i = 0; i < N_DEV; i++) r_arr[i] <= '0;
        end
        default: r_cnt <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_smc_seq.sv
// tb_smc_seq: directed and randomized frames checked against a sort-and-sum reference.
module tb_smc_seq;
  localparam int N    = 6;
  localparam int K    = 3;
  localparam int DW   = 3;
  localparam int OUTW = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      mode;
  logic [DW-1:0]   W;
  logic [DW-1:0]   V_GS;
  logic [DW-1:0]   V_DS;
  logic            out_valid;
  logic [OUTW-1:0] out_n;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_strobe = 0;
  int fw[N];
  int fg[N];
  int fd[N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  smc_seq #(.N_DEV(N), .K(K), .DW(DW), .OUTW(OUTW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .W(W), .V_GS(V_GS), .V_DS(V_DS),
    .out_valid(out_valid), .out_n(out_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int dev_val(input int w, input int g, input int d, input bit id);
    int vov;
    vov = (g == 0) ? 0 : g - 1;
    if (vov > d) return id ? (w * (2 * vov * d - d * d)) / 3 : (2 * w * d) / 3;
    return id ? (w * vov * vov) / 3 : (2 * w * vov) / 3;
  endfunction

  function automatic int frame_ref(input logic [1:0] m);
    int v[N];
    int t;
    int base;
    int s;
    for (int i = 0; i < N; i++) v[i] = dev_val(fw[i], fg[i], fd[i], m[0]);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N - 1 - i; j++)
        if (v[j] < v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    base = m[1] ? 0 : N - K;
    s = 0;
    for (int i = 0; i < K; i++) s += v[base+i] * (m[0] ? 3 + i : 1);
    return s % (1 << OUTW);
  endfunction

  task automatic send(input int w, input int g, input int d, input logic [1:0] md, input int gap);
    int n;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    W = DW'(w); V_GS = DW'(g); V_DS = DW'(d); mode = md;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    W = DW'($urandom); V_GS = DW'($urandom); V_DS = DW'($urandom);
  endtask

  task automatic frame_end(input int exp, input bit junk, input string tag);
    int n;
    if (junk) begin
      in_valid = 1'b1; W = 7; V_GS = 7; V_DS = 7; mode = 2'b11;
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 12);
    check({tag, "_latency"}, n, 2);
    check({tag, "_out"}, out_n, exp);
    last_strobe = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_pulse"}, out_valid, 0);
    check({tag, "_ready"}, in_ready, 1);
    check({tag, "_outzero"}, out_n, 0);
  endtask

  task automatic run_frame(input logic [1:0] md, input int maxgap, input bit junk,
                           input int exp, input string tag);
    int e;
    for (int i = 0; i < N; i++)
      send(fw[i], fg[i], fd[i], (i == 0) ? md : 2'($urandom),
           (i == 0 || maxgap == 0) ? 0 : int'($urandom_range(maxgap, 1)));
    e = (exp < 0) ? frame_ref(md) : exp;
    frame_end(e, junk, tag);
    $display("frame %s mode=%0d out=%0d exp=%0d", tag, md, out_n, e);
  endtask

  task automatic fill(input int w, input int g, input int d);
    for (int i = 0; i < N; i++) begin fw[i] = w; fg[i] = g; fd[i] = d; end
  endtask

  task automatic fill_mixed();
    fw = '{7, 3, 3, 1, 7, 2};
    fg = '{7, 5, 3, 0, 4, 4};
    fd = '{7, 2, 7, 0, 1, 7};
  endtask

  initial begin
    int s1;
    rst = 1'b1; in_valid = 1'b0; mode = 2'b00; W = '0; V_GS = '0; V_DS = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_out", out_n, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    fill(3, 3, 7);
    run_frame(2'b00, 0, 1'b0, 12, "uni4_gm_small");
    run_frame(2'b01, 0, 1'b0, 48, "uni4_id_small");
    fill(7, 7, 7);
    run_frame(2'b11, 0, 1'b0, 1008, "uni84_id_large");
    run_frame(2'b10, 0, 1'b0, 84, "uni84_gm_large");

    fill_mixed();
    run_frame(2'b11, 0, 1'b0, 355, "mix_11");
    run_frame(2'b01, 0, 1'b0, 34, "mix_01");
    run_frame(2'b10, 0, 1'b0, 36, "mix_10");
    run_frame(2'b00, 0, 1'b0, 8, "mix_00");

    run_frame(2'b11, 3, 1'b1, 355, "gap_11");
    run_frame(2'b01, 3, 1'b1, 34, "gap_01");
    run_frame(2'b10, 3, 1'b1, 36, "gap_10");
    run_frame(2'b00, 3, 1'b1, 8, "gap_00");

    for (int i = 0; i < 3; i++) send(fw[i], fg[i], fd[i], 2'b00, 0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_valid", out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready", in_ready, 1);
    fill(7, 7, 7);
    run_frame(2'b11, 0, 1'b0, 1008, "after_abort");

    run_frame(2'b11, 0, 1'b0, 1008, "b2b_first");
    s1 = last_strobe;
    fill_mixed();
    run_frame(2'b00, 0, 1'b0, 8, "b2b_second");
    check("b2b_spacing", last_strobe - s1, N + 2);

    for (int f = 0; f < 24; f++) begin
      for (int i = 0; i < N; i++) begin
        fw[i] = $urandom_range(7, 0);
        fg[i] = $urandom_range(7, 0);
        fd[i] = $urandom_range(7, 0);
      end
      run_frame(2'($urandom), int'($urandom_range(2, 0)), 1'($urandom), -1, "rand");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
